booth_job_scheduler: RTL and testbench

BOOTH_JOB_SCHEDULER -- requirements
Module: booth_job_scheduler

---
 rtl/booth_sched_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 13 +
 rtl/booth_job_scheduler.sv | 125 ++++++++++++
 tb/tb_booth_job_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/booth_sched_pkg.sv
// rtl/booth_sched_pkg.sv - shared state encoding and defaults for the booth job scheduler
package booth_sched_pkg;
    localparam int DEF_W       = 6;
    localparam int DEF_TIMEOUT = 15;
    localparam int NREQ        = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_X,
        SEND_Y,
        WAIT,
        READ_LO,
        RESP
    } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, one-hot output
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    // On contention the requester that was not served last wins.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end
endmodule

// File: rtl/booth_job_scheduler.sv
// rtl/booth_job_scheduler.sv - arbitrates two requesters onto a shared booth multiplier
module booth_job_scheduler
    import booth_sched_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [W-1:0]      x0,
    input  logic [W-1:0]      y0,
    input  logic [W-1:0]      x1,
    input  logic [W-1:0]      y1,
    output logic [NREQ-1:0]   ack,
    output logic [2*W-1:0]    product,
    output logic              err,
    output logic              busy,
    output logic              mul_start,
    output logic [W-1:0]      mul_in,
    input  logic              mul_done,
    input  logic [W-1:0]      mul_out
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic            gidx;
    logic            prio;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic            err_r;
    logic [1:0]      gnt;
    logic            tmo_hit;

    // prio names the requester favoured next; the arbiter wants the last-served one.
    rr_arbiter2 u_arb (
        .req  (req),
        .last (~prio),
        .gnt  (gnt)
    );

    assign tmo_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gidx  <= 1'b0;
            prio  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:    if (|req) gidx <= gnt[1];
                START: begin
                    err_r <= 1'b0;
                    hi    <= '0;
                    lo    <= '0;
                end
                SEND_Y:  cnt <= '0;
                WAIT: begin
                    if (mul_done) begin
                        hi <= mul_out;
                    end else begin
                        if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
                        if (tmo_hit) err_r <= 1'b1;
                    end
                end
                READ_LO: lo <= mul_out;
                RESP:    prio <= ~gidx;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = '0;
        product   = '0;
        err       = 1'b0;
        busy      = (state != IDLE);
        mul_start = 1'b0;
        mul_in    = '0;
        case (state)
            IDLE:    if (|req) state_nxt = START;
            START: begin
                mul_start = 1'b1;
                state_nxt = SEND_X;
            end
            SEND_X: begin
                mul_in    = gidx ? x1 : x0;
                state_nxt = SEND_Y;
            end
            SEND_Y: begin
                mul_in    = gidx ? y1 : y0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done)     state_nxt = READ_LO;
                else if (tmo_hit) state_nxt = RESP;
            end
            READ_LO: state_nxt = RESP;
            RESP: begin
                ack[gidx] = 1'b1;
                err       = err_r;
                product   = err_r ? '0 : {hi, lo};
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are forced quiet while reset is asserted, even before the edge lands.
        if (rst) begin
            ack       = '0;
            product   = '0;
            err       = 1'b0;
            busy      = 1'b0;
            mul_start = 1'b0;
            mul_in    = '0;
        end
    end
endmodule

// File: tb/tb_booth_job_scheduler.sv
// tb/tb_booth_job_scheduler.sv - directed self-checking bench for booth_job_scheduler
module tb_booth_job_scheduler;
    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [5:0]  x0, y0, x1, y1;
    logic [1:0]  ack;
    logic [11:0] product;
    logic        err;
    logic        busy;
    logic        mul_start;
    logic [5:0]  mul_in;
    logic        mul_done;
    logic [5:0]  mul_out;

    int checks = 0;
    int errors = 0;

    booth_job_scheduler #(.W(6), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .ack       (ack),
        .product   (product),
        .err       (err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_in    (mul_in),
        .mul_done  (mul_done),
        .mul_out   (mul_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_start"}, 32'(mul_start), 0);
        chk({tag, "_mulin"}, 32'(mul_in), 0);
        chk({tag, "_prod"}, 32'(product), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // Runs one job from the current negedge; the bench plays the multiplier.
    task automatic job(input logic [1:0] reqv, input logic [1:0] exp_ack,
                       input logic [5:0] ex, input logic [5:0] ey,
                       input logic [5:0] hv, input logic [5:0] lv,
                       input int nwait, input bit tmo,
                       input logic [11:0] ep, input bit ee,
                       input logic [1:0] drop);
        int n;
        req = reqv;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mul_start) break;
        end
        chk("start_seen", 32'(mul_start), 1);
        if (!mul_start) return;
        chk("mulin_start", 32'(mul_in), 0);
        @(negedge clk);
        chk("mulin_x", 32'(mul_in), 32'(ex));
        chk("start_pulse", 32'(mul_start), 0);
        @(negedge clk);
        chk("mulin_y", 32'(mul_in), 32'(ey));
        @(negedge clk);
        chk("mulin_wait", 32'(mul_in), 0);
        if (tmo) begin
            n = 0;
            while (ack == 2'b00 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_cycles", 32'(n), 15);
        end else begin
            repeat (nwait - 1) @(negedge clk);
            chk("no_early_ack", 32'(ack), 0);
            mul_done = 1'b1;
            mul_out  = hv;
            @(negedge clk);
            mul_done = 1'b0;
            mul_out  = lv;
            @(negedge clk);
        end
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("product", 32'(product), 32'(ep));
        chk("err", 32'(err), 32'(ee));
        req     = req & ~drop;
        mul_out = '0;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 2'b00;
        x0       = 6'd5;
        y0       = 6'd3;
        x1       = 6'h3D;
        y1       = 6'd7;
        mul_done = 1'b0;
        mul_out  = '0;
        repeat (2) @(negedge clk);
        quiet("in_reset");
        rst = 1'b0;
        @(negedge clk);
        quiet("post_reset");

        // Contention straight out of reset: 0,1,0,1 with both held high.
        job(2'b11, 2'b01, 6'd5,  6'd3, 6'h01, 6'h02, 2, 1'b0, 12'h042, 1'b0, 2'b00);
        job(2'b11, 2'b10, 6'h3D, 6'd7, 6'h03, 6'h04, 1, 1'b0, 12'h0C4, 1'b0, 2'b00);
        job(2'b11, 2'b01, 6'd5,  6'd3, 6'h05, 6'h06, 1, 1'b0, 12'h146, 1'b0, 2'b00);
        job(2'b11, 2'b10, 6'h3D, 6'd7, 6'h07, 6'h08, 3, 1'b0, 12'h1C8, 1'b0, 2'b11);
        @(negedge clk);
        chk("idle_after_rr", 32'(busy), 0);

        // Single unsigned job, then a signed one (-3 * 7 = -21).
        job(2'b01, 2'b01, 6'd5, 6'd3, 6'h00, 6'h0F, 3, 1'b0, 12'h00F, 1'b0, 2'b01);
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 0);
        chk("prod_outside_resp", 32'(product), 0);
        job(2'b10, 2'b10, 6'h3D, 6'd7, 6'h3F, 6'h2B, 1, 1'b0, 12'hFEB, 1'b0, 2'b10);

        // Multiplier never answers.
        job(2'b01, 2'b01, 6'd5, 6'd3, 6'h00, 6'h00, 0, 1'b1, 12'h000, 1'b1, 2'b01);
        @(negedge clk);
        chk("idle_after_tmo", 32'(busy), 0);
        chk("err_after_tmo", 32'(err), 0);

        // Reset while waiting on the multiplier; requester keeps req high.
        req = 2'b01;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mul_start) break;
        end
        repeat (5) @(negedge clk);
        chk("busy_mid_wait", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        quiet("after_mid_rst");
        job(2'b01, 2'b01, 6'd5, 6'd3, 6'h00, 6'h0F, 2, 1'b0, 12'h00F, 1'b0, 2'b01);

        // Stray done with nobody requesting.
        @(negedge clk);
        mul_done = 1'b1;
        mul_out  = 6'h2A;
        @(negedge clk);
        mul_done = 1'b0;
        quiet("stray1");
        @(negedge clk);
        quiet("stray2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
